memory_reader: RTL and testbench

//  Read-back path for the 4-bank NPU result/operand memory (4 x 8K x 16-bit words, byte-addressed 0x0000-0xFFFF).

---
 rtl/npu_mem_pkg.sv | 10 +
 rtl/memory_reader.sv | 117 +++++++++++
 tb/tb_memory_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_mem_pkg.sv
// Shared definitions for the 4-bank NPU result/operand memory.
// The read and write paths both import this, so the bank map lives in one place.
package npu_mem_pkg;
    localparam int BANK_BITS   = 2;
    localparam int WORD_ADDR_W = 13;
    localparam logic [15:0] BANK_BASE [4] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, FIN} rd_state_t;
    typedef logic [15:0] mem_word_t;
endpackage

// File: rtl/memory_reader.sv
// Read-back path: fetches 16-bit words from the four banks and streams them
// out low byte first, with a ready/valid handshake toward the host transmitter.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | register word address and bank index
// WAIT  | RAM read latency, capture selected bank q at the end
// SEND  | present one byte, advance on accept
// FIN   | one-cycle done pulse
module memory_reader
    import npu_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            start_addr,
    input  logic [15:0]            byte_count,
    output logic [WORD_ADDR_W-1:0] ram_address,
    input  mem_word_t              ramIn1,
    input  mem_word_t              ramIn2,
    input  mem_word_t              ramIn3,
    input  mem_word_t              ramIn4,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   done
);
    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    rd_state_t             state, state_nxt;
    logic [15:0]           addr;
    logic [15:0]           cnt;
    logic [BANK_BITS-1:0]  bank;
    logic [1:0]            lat_cnt;
    mem_word_t             word_buf;
    mem_word_t             bank_q;
    logic                  accept;

    always_comb begin
        case (bank)
            2'd0:    bank_q = ramIn1;
            2'd1:    bank_q = ramIn2;
            2'd2:    bank_q = ramIn3;
            default: bank_q = ramIn4;
        endcase
    end

    assign accept = (state == SEND) && byte_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (byte_count == 16'd0) ? FIN : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == 2'd0) state_nxt = SEND;
            SEND: begin
                if (accept) begin
                    // Even byte just sent means the high byte is already buffered.
                    if (cnt == 16'd1)      state_nxt = FIN;
                    else if (!addr[0])     state_nxt = SEND;
                    else                   state_nxt = ISSUE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            cnt         <= '0;
            bank        <= '0;
            lat_cnt     <= '0;
            word_buf    <= '0;
            ram_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr <= start_addr;
                        cnt  <= byte_count;
                    end
                end
                ISSUE: begin
                    ram_address <= addr[13:1];
                    bank        <= addr[15:14];
                    lat_cnt     <= LAT_LOAD;
                end
                WAIT: begin
                    if (lat_cnt != 2'd0) lat_cnt  <= lat_cnt - 2'd1;
                    else                 word_buf <= bank_q;
                end
                SEND: begin
                    if (byte_ready) begin
                        addr <= addr + 16'd1;
                        cnt  <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_valid = (state == SEND);
    assign byte_out   = addr[0] ? word_buf[15:8] : word_buf[7:0];
    assign busy       = (state == ISSUE) || (state == WAIT) || (state == SEND);
    assign done       = (state == FIN);
endmodule

// File: tb/tb_memory_reader.sv
// Bench for memory_reader: two instances (read latency 1 and 2) against
// modelled bank RAMs, with a byte scoreboard filled from the memory model.
module tb_memory_reader;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [15:0] start_addr;
    logic [15:0] byte_count;
    logic byte_ready;
    logic lsel;

    logic [12:0] ra1, ra2;
    logic [15:0] q1 [4];
    logic [15:0] q2 [4];
    logic [7:0]  bo1, bo2;
    logic        bv1, bv2, by1, by2, dn1, dn2;

    logic [15:0] mem [32768];
    logic [7:0]  exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    logic [7:0]  byte_out;
    logic        byte_valid, busy, done;
    logic [12:0] ram_address;
    assign byte_out    = lsel ? bo2 : bo1;
    assign byte_valid  = lsel ? bv2 : bv1;
    assign busy        = lsel ? by2 : by1;
    assign done        = lsel ? dn2 : dn1;
    assign ram_address = lsel ? ra2 : ra1;

    always #5 clk = ~clk;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        localparam logic [1:0] BK = 2'(b);
        assign q1[b] = mem[{BK, ra1}];
        always @(posedge clk) q2[b] <= mem[{BK, ra2}];
    end

    memory_reader #(.READ_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .byte_count(byte_count),
        .ram_address(ra1), .ramIn1(q1[0]), .ramIn2(q1[1]), .ramIn3(q1[2]), .ramIn4(q1[3]),
        .byte_out(bo1), .byte_valid(bv1), .byte_ready(byte_ready), .busy(by1), .done(dn1)
    );

    memory_reader #(.READ_LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .byte_count(byte_count),
        .ram_address(ra2), .ramIn1(q2[0]), .ramIn2(q2[1]), .ramIn3(q2[2]), .ramIn4(q2[3]),
        .byte_out(bo2), .byte_valid(bv2), .byte_ready(byte_ready), .busy(by2), .done(dn2)
    );

    // Starts a transfer, scoreboards every accepted byte and returns cycles from start to done.
    task automatic run_xfer(input logic [15:0] a, input logic [15:0] n, input bit rnd,
                            input bit poke, output int cycles);
        logic [15:0] ea;
        logic [15:0] w;
        logic [7:0]  held;
        bit stalled;
        bit fin;
        int cyc;
        for (int i = 0; i < int'(n); i++) begin
            ea = a + 16'(i);
            w  = mem[ea[15:1]];
            exp_q.push_back(ea[0] ? w[15:8] : w[7:0]);
        end
        @(negedge clk);
        start = 1'b1; start_addr = a; byte_count = n; byte_ready = 1'b1;
        stalled = 1'b0; fin = 1'b0; cyc = 0; held = '0; cycles = -1;
        while (!fin && cyc < 400 + 8 * int'(n)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1; start_addr = 16'h9999; byte_count = 16'd7;
            end
            if (cyc == 1 && n != 16'd0) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL busy_rise L=%0d: got %b expected 1", lat, busy);
                end
            end
            if (stalled) begin
                n_tests++;
                if (byte_valid !== 1'b1 || byte_out !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold L=%0d: got valid=%b byte=%h expected valid=1 byte=%h",
                             lat, byte_valid, byte_out, held);
                end
            end
            if (done === 1'b1) begin
                fin = 1'b1; cycles = cyc;
                n_tests++;
                if (exp_q.size() != 0) begin
                    n_fail++; $display("FAIL missing_bytes L=%0d: got %0d left expected 0", lat, exp_q.size());
                end
                n_tests++;
                if (byte_valid !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL fin_outputs L=%0d: got valid=%b busy=%b expected 0 0", lat, byte_valid, busy);
                end
                exp_q.delete();
            end else if (byte_valid === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL extra_byte L=%0d: got %h expected none", lat, byte_out);
                end else if (byte_out !== exp_q[0]) begin
                    n_fail++; $display("FAIL byte_data L=%0d: got %h expected %h", lat, byte_out, exp_q[0]);
                end
                byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (byte_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held = byte_out;
                end
            end else begin
                stalled = 1'b0;
                byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!fin) begin
            n_tests++; n_fail++;
            $display("FAIL xfer_timeout L=%0d: got no done expected done", lat);
            exp_q.delete();
        end else begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL after_done L=%0d: got done=%b busy=%b expected 0 0", lat, done, busy);
            end
        end
        byte_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_addr = '0; byte_count = '0; byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (byte_out !== 8'h00 || byte_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_address !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_state L=%0d: got byte=%h valid=%b busy=%b done=%b ra=%h expected all 0",
                     lat, byte_out, byte_valid, busy, done, ram_address);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        mem[0] = 16'hBEEF;
        run_xfer(16'h0000, 16'd2, 1'b0, 1'b0, cyc);
        n_tests++;
        if (cyc != 4 + lat) begin
            n_fail++; $display("FAIL basic_latency L=%0d: got %0d cycles expected %0d", lat, cyc, 4 + lat);
        end
        run_xfer(16'h0010, 16'd6, 1'b0, 1'b0, cyc);
        n_tests++;
        if (cyc != 3 * (3 + lat) + 1) begin
            n_fail++; $display("FAIL throughput L=%0d: got %0d cycles expected %0d", lat, cyc, 3 * (3 + lat) + 1);
        end
    endtask

    task automatic test_bank_cross();
        int cyc;
        mem[15'h1FFF] = 16'h12AB;
        mem[15'h2000] = 16'h5634;
        run_xfer(16'h3FFF, 16'd3, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_wrap();
        int cyc;
        mem[15'h7FFF] = 16'h7700;
        mem[15'h0000] = 16'h0099;
        run_xfer(16'hFFFF, 16'd2, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_zero();
        int cyc;
        run_xfer(16'h1234, 16'd0, 1'b0, 1'b0, cyc);
        n_tests++;
        if (cyc != 1) begin
            n_fail++; $display("FAIL zero_count L=%0d: got done after %0d cycles expected 1", lat, cyc);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        run_xfer(16'h0020, 16'd4, 1'b0, 1'b1, cyc);
    endtask

    task automatic test_random_ready();
        int cyc;
        run_xfer(16'h1233, 16'd64, 1'b1, 1'b0, cyc);
    endtask

    task automatic test_reset_abort();
        int cyc;
        bit seen;
        mem[15'h4000] = 16'h3C5A;
        @(negedge clk);
        start = 1'b1; start_addr = 16'h0100; byte_count = 16'd10; byte_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (byte_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL abort_reach_send L=%0d: got no valid expected valid", lat);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (byte_out !== 8'h00 || byte_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset_outputs L=%0d: got byte=%h valid=%b busy=%b done=%b expected 0",
                     lat, byte_out, byte_valid, busy, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_done L=%0d: got done=%b busy=%b expected 0 0", lat, done, busy);
            end
        end
        run_xfer(16'h8000, 16'd1, 1'b0, 1'b0, cyc);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;
        rst = 1'b1; start = 1'b0; start_addr = '0; byte_count = '0; byte_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            lsel = 1'(s);
            lat  = s + 1;
            test_reset();
            test_basic();
            test_bank_cross();
            test_wrap();
            test_zero();
            test_start_ignored();
            test_random_ready();
            test_reset_abort();
            rst = 1'b1;
            @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
